// File: rtl/rgb2ycbcr_package.sv
// Shared types for the RGB->YCbCr pipeline: pixel layout and the packer FSM states.
package rgb2ycbcr_package;

  localparam int unsigned CHANNEL_WIDTH = 8;
  localparam int unsigned NB_CHANNELS   = 3;
  localparam int unsigned PIXEL_WIDTH   = NB_CHANNELS * CHANNEL_WIDTH;

  // Little-endian memory layout: byte 0 = B, byte 1 = G, byte 2 = R.
  typedef struct packed {
    logic [CHANNEL_WIDTH-1:0] r;
    logic [CHANNEL_WIDTH-1:0] g;
    logic [CHANNEL_WIDTH-1:0] b;
  } rgb_struct;

  typedef enum logic {
    PACK_FILL,
    PACK_FULL
  } pack_state_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// HWPE stream handshake bundle: a beat transfers on a cycle where valid && ready;
// once valid is raised, data/strb/valid hold steady until that transfer.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/hwpe_rgb_stream_packer.sv
// Packs narrow 24-bpp RGB memory words into wide pixel beats for the colour converter,
// with an end-of-frame flush that emits a partial beat with zeroed unused slots.
module hwpe_rgb_stream_packer
  import rgb2ycbcr_package::*;
#(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 96
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   flush,
  hwpe_stream_intf_stream.sink   rgb_in,
  hwpe_stream_intf_stream.source rgb_out,
  output logic                   busy
);

  localparam int unsigned RATIO    = OUT_WIDTH / IN_WIDTH;
  localparam int unsigned IN_STRB  = IN_WIDTH / 8;
  localparam int unsigned OUT_STRB = OUT_WIDTH / 8;
  localparam int unsigned IDX_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  if ((OUT_WIDTH % IN_WIDTH != 0) || (OUT_WIDTH % PIXEL_WIDTH != 0)) begin : g_bad_widths
    $error("hwpe_rgb_stream_packer: OUT_WIDTH must be a multiple of IN_WIDTH and PIXEL_WIDTH");
  end

  pack_state_t          state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [OUT_WIDTH-1:0] data_q;
  logic [OUT_STRB-1:0]  strb_q;
  logic                 in_hs;
  logic                 out_hs;
  logic                 close_beat;

  assign rgb_in.ready  = (state_q == PACK_FILL) || rgb_out.ready;
  assign rgb_out.valid = (state_q == PACK_FULL);
  assign rgb_out.data  = data_q;
  assign rgb_out.strb  = strb_q;
  assign busy          = (idx_q != '0) || (state_q == PACK_FULL);

  assign in_hs      = rgb_in.valid && rgb_in.ready;
  assign out_hs     = (state_q == PACK_FULL) && rgb_out.ready;
  assign close_beat = (in_hs && (idx_q == LAST_IDX)) || (flush && (in_hs || (idx_q != '0)));

  // Slots at or above idx are kept at zero while filling, so a flushed beat
  // needs no extra masking of its unused slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PACK_FILL;
      idx_q   <= '0;
      data_q  <= '0;
      strb_q  <= '0;
    end else if (clear) begin
      state_q <= PACK_FILL;
      idx_q   <= '0;
      data_q  <= '0;
      strb_q  <= '0;
    end else begin
      unique case (state_q)
        PACK_FILL: begin
          if (in_hs) begin
            for (int unsigned s = 0; s < RATIO; s++) begin
              if (idx_q == IDX_W'(s)) begin
                data_q[s*IN_WIDTH +: IN_WIDTH] <= rgb_in.data;
                strb_q[s*IN_STRB +: IN_STRB]   <= rgb_in.strb;
              end
            end
          end
          if (close_beat) begin
            state_q <= PACK_FULL;
            idx_q   <= '0;
          end else if (in_hs) begin
            idx_q <= idx_q + 1'b1;
          end
        end
        PACK_FULL: begin
          if (out_hs) begin
            if (rgb_in.valid) begin
              // Back-to-back: the incoming word starts the next beat in slot 0.
              data_q  <= OUT_WIDTH'(rgb_in.data);
              strb_q  <= OUT_STRB'(rgb_in.strb);
              state_q <= (RATIO == 1) ? PACK_FULL : PACK_FILL;
              idx_q   <= (RATIO == 1) ? '0 : IDX_W'(1);
            end else begin
              data_q  <= '0;
              strb_q  <= '0;
              state_q <= PACK_FILL;
              idx_q   <= '0;
            end
          end
        end
        default: state_q <= PACK_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_hwpe_rgb_stream_packer.sv
// Bench for hwpe_rgb_stream_packer: directed stimulus, a word-queue model of beat
// formation checked every cycle, and literal expectations for the directed scenarios.
module tb_hwpe_rgb_stream_packer;
  import rgb2ycbcr_package::*;

  localparam int unsigned IN_W  = 32;
  localparam int unsigned OUT_W = 96;
  localparam int unsigned RATIO = OUT_W / IN_W;
  localparam int unsigned IN_S  = IN_W / 8;
  localparam int unsigned OUT_S = OUT_W / 8;

  logic clk;
  logic rst_n;
  logic clear;
  logic flush;
  logic busy;

  hwpe_stream_intf_stream #(.DATA_WIDTH(IN_W))  rgb_in_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(OUT_W)) rgb_out_if ();

  hwpe_rgb_stream_packer #(
    .IN_WIDTH (IN_W),
    .OUT_WIDTH(OUT_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .flush  (flush),
    .rgb_in (rgb_in_if),
    .rgb_out(rgb_out_if),
    .busy   (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;
  int n_beats  = 0;
  int beats0;
  rgb_struct px;

  logic [IN_S+IN_W-1:0]   word_q[$];
  logic [OUT_S+OUT_W-1:0] exp_q[$];
  logic                   held;
  logic [OUT_W-1:0]       m_data;
  logic [OUT_S-1:0]       m_strb;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: words gather until RATIO or a flush closes a beat
  always @(negedge clk) begin
    if (!rst_n) begin
      word_q.delete();
      exp_q.delete();
    end else begin
      held = (exp_q.size() != 0);
      check_bit("out_valid", rgb_out_if.valid, held);
      check_bit("busy", busy, held || (word_q.size() != 0));
      check_bit("in_ready", rgb_in_if.ready, !held || rgb_out_if.ready);
      if (clear) begin
        word_q.delete();
        exp_q.delete();
      end else begin
        if (rgb_out_if.valid && rgb_out_if.ready && held) begin
          check_vec("beat_data", 128'(rgb_out_if.data), 128'(exp_q[0][OUT_W-1:0]));
          check_vec("beat_strb", 128'(rgb_out_if.strb), 128'(exp_q[0][OUT_W +: OUT_S]));
          void'(exp_q.pop_front());
          n_beats++;
        end
        if (rgb_in_if.valid && rgb_in_if.ready)
          word_q.push_back({rgb_in_if.strb, rgb_in_if.data});
        if ((word_q.size() == int'(RATIO)) || (flush && !held && (word_q.size() != 0))) begin
          m_data = '0;
          m_strb = '0;
          for (int k = 0; k < word_q.size(); k++) begin
            m_data = m_data | (OUT_W'(word_q[k][IN_W-1:0]) << (k * IN_W));
            m_strb = m_strb | (OUT_S'(word_q[k][IN_W +: IN_S]) << (k * IN_S));
          end
          exp_q.push_back({m_strb, m_data});
          word_q.delete();
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic [IN_W-1:0] d, input logic [IN_S-1:0] s);
    rgb_in_if.valid = 1'b1;
    rgb_in_if.data  = d;
    rgb_in_if.strb  = s;
  endtask

  task automatic idle();
    rgb_in_if.valid = 1'b0;
    rgb_in_if.data  = '0;
    rgb_in_if.strb  = '0;
    flush = 1'b0;
    clear = 1'b0;
  endtask

  task automatic check_beat(input string name, input logic [OUT_W-1:0] d, input logic [OUT_S-1:0] s);
    check_bit({name, "_valid"}, rgb_out_if.valid, 1'b1);
    check_vec({name, "_data"}, 128'(rgb_out_if.data), 128'(d));
    check_vec({name, "_strb"}, 128'(rgb_out_if.strb), 128'(s));
  endtask

  initial begin
    rst_n = 1'b0;
    rgb_out_if.ready = 1'b1;
    idle();
    repeat (3) step();
    sample();
    check_bit("rst_valid", rgb_out_if.valid, 1'b0);
    check_vec("rst_data", 128'(rgb_out_if.data), 128'(0));
    check_vec("rst_strb", 128'(rgb_out_if.strb), 128'(0));
    check_bit("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    step();
    sample();
    check_bit("ready_after_reset", rgb_in_if.ready, 1'b1);

    // single beat, one-cycle latency
    step(); drive(32'h44332211, 4'hF);
    step(); drive(32'h88776655, 4'hF);
    step(); drive(32'hCCBBAA99, 4'hF);
    sample();
    check_bit("t1_not_early", rgb_out_if.valid, 1'b0);
    step(); idle();
    sample();
    check_beat("t1_beat", 96'hCCBBAA99_88776655_44332211, 12'hFFF);
    px = rgb_struct'(rgb_out_if.data[PIXEL_WIDTH-1:0]);
    check_vec("t1_px0_b", 128'(px.b), 128'(8'h11));
    check_vec("t1_px0_g", 128'(px.g), 128'(8'h22));
    check_vec("t1_px0_r", 128'(px.r), 128'(8'h33));
    step();
    sample();
    check_bit("t1_one_cycle", rgb_out_if.valid, 1'b0);

    // 12 back-to-back words, varied strobes
    beats0 = n_beats;
    for (int i = 0; i < 12; i++) begin
      step();
      drive(32'hA0000000 | 32'(i * 32'h00010101), 4'((i % 15) + 1));
      sample();
      check_bit("t2_no_bubble", rgb_in_if.ready, 1'b1);
    end
    step(); idle();
    repeat (3) step();
    sample();
    check_vec("t2_beats", 128'(n_beats - beats0), 128'(4));

    // flush after two words, then flush together with the second word
    step(); drive(32'h0A0B0C0D, 4'hF);
    step(); drive(32'h1A1B1C1D, 4'hF);
    step(); idle(); flush = 1'b1;
    sample();
    check_bit("t3_busy_partial", busy, 1'b1);
    step(); flush = 1'b0;
    sample();
    check_beat("t3_flush_beat", {32'h0, 32'h1A1B1C1D, 32'h0A0B0C0D}, 12'h0FF);
    step(); drive(32'h2A2B2C2D, 4'hF);
    step(); drive(32'h3A3B3C3D, 4'hF); flush = 1'b1;
    step(); idle();
    sample();
    check_beat("t3_flush_same", {32'h0, 32'h3A3B3C3D, 32'h2A2B2C2D}, 12'h0FF);

    // backpressure: beat held for 5 cycles, flush in FULL ignored
    step(); rgb_out_if.ready = 1'b0; drive(32'h11111111, 4'hF);
    step(); drive(32'h22222222, 4'hF);
    step(); drive(32'h33333333, 4'hF);
    step(); drive(32'h44444444, 4'hF);
    for (int c = 0; c < 5; c++) begin
      flush = (c == 2);
      sample();
      check_beat("t4_hold", {32'h33333333, 32'h22222222, 32'h11111111}, 12'hFFF);
      check_bit("t4_in_ready_low", rgb_in_if.ready, 1'b0);
      step();
    end
    flush = 1'b0;
    rgb_out_if.ready = 1'b1;
    sample();
    check_bit("t4_release_ready", rgb_in_if.ready, 1'b1);
    step(); idle();
    sample();
    check_bit("t4_busy_slot0", busy, 1'b1);
    check_bit("t4_valid_low", rgb_out_if.valid, 1'b0);
    step(); drive(32'h55555555, 4'hF);
    step(); drive(32'h66666666, 4'hF);
    step(); idle();
    sample();
    check_beat("t4_next_beat", {32'h66666666, 32'h55555555, 32'h44444444}, 12'hFFF);

    // flush at idx 0 is ignored; clear drops the partial beat and the same-cycle word
    step(); flush = 1'b1;
    sample();
    step(); flush = 1'b0;
    sample();
    check_bit("t5_flush_idle_valid", rgb_out_if.valid, 1'b0);
    check_bit("t5_flush_idle_busy", busy, 1'b0);
    step(); drive(32'hDEAD0001, 4'hF);
    step(); drive(32'hDEAD0002, 4'hF);
    step(); drive(32'hDEAD0003, 4'hF); clear = 1'b1;
    sample();
    check_bit("t5_busy_before_clear", busy, 1'b1);
    step(); idle();
    sample();
    check_bit("t5_clear_valid", rgb_out_if.valid, 1'b0);
    check_bit("t5_clear_busy", busy, 1'b0);
    step(); drive(32'h01020304, 4'hF);
    step(); drive(32'h05060708, 4'hF);
    step(); drive(32'h090A0B0C, 4'hF);
    step(); idle();
    sample();
    check_beat("t5_clean_beat", {32'h090A0B0C, 32'h05060708, 32'h01020304}, 12'hFFF);

    // async reset mid-beat
    step(); drive(32'hBADBAD00, 4'hF);
    step(); idle();
    sample();
    check_bit("t6_busy_mid", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_bit("t6_rst_valid", rgb_out_if.valid, 1'b0);
    check_vec("t6_rst_data", 128'(rgb_out_if.data), 128'(0));
    check_vec("t6_rst_strb", 128'(rgb_out_if.strb), 128'(0));
    check_bit("t6_rst_busy", busy, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    sample();
    check_bit("t6_ready_after", rgb_in_if.ready, 1'b1);
    repeat (3) step();
    sample();
    check_bit("t6_no_stale", rgb_out_if.valid, 1'b0);
    step(); drive(32'hF00DF00D, 4'hF);
    step(); drive(32'hCAFEBABE, 4'h7);
    step(); drive(32'h12345678, 4'hF);
    step(); idle();
    sample();
    check_beat("t6_fresh_beat", {32'h12345678, 32'hCAFEBABE, 32'hF00DF00D}, 12'hF7F);

    repeat (3) step();
    sample();
    check_vec("end_exp_empty", 128'(exp_q.size()), 128'(0));
    check_vec("end_words_empty", 128'(word_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
